// File: rtl/fp16_to_fix16.sv
// Two-stage fp16 -> signed 16-bit integer converter with valid/ready on both sides.
// Define FP16_TO_FIX16_ROUND_EN for round-half-to-even; otherwise magnitudes truncate toward zero.
module fp16_to_fix16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        out_inexact
);

  // Stage-1 word: classified input plus the shift needed to denormalize m.
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic        sat;
    logic        left;
    logic [3:0]  sh;
    logic [10:0] m;
  } s1_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
    logic        inexact;
  } res_t;

  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic s1_en, s2_en;
  s1_t  s1_q, s1_d, dec;
  res_t s2_q, s2_d, cnv;

  logic [4:0]  ex;
  logic [15:0] m16, mask, disc, mag;
`ifdef FP16_TO_FIX16_ROUND_EN
  logic guard, sticky;
`endif

  assign s2_en    = ~s2_v_q | out_ready;
  assign s1_en    = ~s1_v_q | s2_en;
  assign in_ready = s1_en;

  // Decode: exp >= 25 shifts left by exp-25, else right by 25-exp.
  // Anything at or below exp 13 loses every bit, so clamp to a shift of 12.
  always_comb begin
    ex       = in_data[14:10];
    dec      = '0;
    dec.sign = in_data[15];
    dec.zero = (ex == 5'd0);
    dec.sat  = (ex >= 5'd30);
    dec.left = (ex >= 5'd25);
    dec.m    = {1'b1, in_data[9:0]};
    if (dec.left)
      dec.sh = 4'(ex - 5'd25);
    else if (ex <= 5'd13)
      dec.sh = 4'd12;
    else
      dec.sh = 4'(5'd25 - ex);
  end

  always_comb begin
    m16  = {5'b0, s1_q.m};
    mask = (16'h1 << s1_q.sh) - 16'h1;
    disc = m16 & mask;
    mag  = '0;
    cnv  = '0;
`ifdef FP16_TO_FIX16_ROUND_EN
    guard  = |(disc & (16'h1 << (s1_q.sh - 4'd1)));
    sticky = |(disc & ((16'h1 << (s1_q.sh - 4'd1)) - 16'h1));
`endif
    if (s1_q.zero) begin
      cnv = '0;
    end else if (s1_q.sat) begin
      cnv.data = s1_q.sign ? 16'h8000 : 16'h7FFF;
      cnv.sat  = 1'b1;
    end else begin
      if (s1_q.left) begin
        mag = m16 << s1_q.sh;
      end else begin
        mag         = m16 >> s1_q.sh;
        cnv.inexact = |disc;
`ifdef FP16_TO_FIX16_ROUND_EN
        // Right shift is always >= 1 here, so the guard bit exists; max result is 1024.
        if (guard & (sticky | mag[0]))
          mag = mag + 16'h1;
`endif
      end
      cnv.data = s1_q.sign ? -mag : mag;
    end
  end

  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    s2_v_d = s2_v_q;
    s2_d   = s2_q;
    if (s1_en) begin
      s1_v_d = in_valid;
      if (in_valid)
        s1_d = dec;
    end
    if (s2_en) begin
      s2_v_d = s1_v_q;
      if (s1_v_q)
        s2_d = cnv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign out_valid   = s2_v_q;
  assign out_data    = s2_q.data;
  assign out_sat     = s2_q.sat;
  assign out_inexact = s2_q.inexact;

endmodule

// File: tb/tb_fp16_to_fix16.sv
// Bench for fp16_to_fix16: directed literals, backpressure, random stall soak, mid-flight reset.
module tb_fp16_to_fix16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_inexact;

  int checks = 0;
  int failures = 0;
  int n_in = 0;
  int n_out = 0;
  logic [17:0] expq[$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out = '0;
  logic        soak_done = 1'b0;

  fp16_to_fix16 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  // Reference: value in units of 2^-25 is m << exp; integer part and remainder by division.
  function automatic logic [17:0] model(input logic [15:0] w);
    logic [4:0] ex;
    longint scaled, q, r, half;
    logic inx;
    logic [15:0] res;
    ex = w[14:10];
    if (ex == 5'd0) return 18'h0;
    scaled = longint'({1'b1, w[9:0]}) << ex;
    if (ex == 5'd31 || scaled >= (longint'(32768) << 25))
      return {(w[15] ? 16'h8000 : 16'h7FFF), 1'b1, 1'b0};
    half = longint'(1) << 24;
    q = scaled / (half * 2);
    r = scaled % (half * 2);
    inx = (r != 0);
`ifdef FP16_TO_FIX16_ROUND_EN
    if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
`endif
    res = 16'(q);
    if (w[15]) res = 16'(0 - q);
    return {res, 1'b0, inx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Scoreboard/compare process, evaluated mid-cycle when all handshakes are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {out_valid, out_data, out_sat, out_inexact}, {1'b1, prev_out});
      if (in_valid && in_ready) begin
        expq.push_back(model(in_data));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        chk("out_has_expect", (expq.size() > 0), 1);
        if (expq.size() > 0)
          chk("scoreboard", {out_data, out_sat, out_inexact}, expq.pop_front());
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = {out_data, out_sat, out_inexact};
    end
  end

  // Empty pipeline, out_ready=1, called at posedge+1.
  task automatic directed(input string name, input logic [15:0] w, input logic [17:0] expv);
    chk({name, "_model"}, model(w), expv);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk); chk({name, "_acc"}, in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk({name, "_lat1"}, out_valid, 0);
    @(negedge clk); chk({name, "_lat2"}, out_valid, 1);
    chk(name, {out_data, out_sat, out_inexact}, expv);
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [15:0] w);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("offer_accepted", acc, 1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    logic [9:0]  mans[4];
    mans = '{10'h000, 10'h200, 10'h100, 10'h3FF};
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      1: w[14:10] = 5'($urandom_range(13, 30));
      2: begin
        w[14:10] = 5'($urandom_range(13, 26));
        w[9:0]   = mans[$urandom_range(0, 3)];
      end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [17:0] r_3e00, r_3a00, r_be00;
    int n0, cnt;
`ifdef FP16_TO_FIX16_ROUND_EN
    r_3e00 = {16'h0002, 2'b01};
    r_3a00 = {16'h0001, 2'b01};
    r_be00 = {16'hFFFE, 2'b01};
`else
    r_3e00 = {16'h0001, 2'b01};
    r_3a00 = {16'h0000, 2'b01};
    r_be00 = {16'hFFFF, 2'b01};
`endif
    #1;
    chk("rst_state", {out_valid, out_data, out_sat, out_inexact}, 0);
    chk("rst_in_ready", in_ready, 1);
    #21 rst_n = 1'b1;
    @(posedge clk); #1 out_ready = 1'b1;

    directed("one",     16'h3C00, {16'h0001, 2'b00});
    directed("neg_one", 16'hBC00, {16'hFFFF, 2'b00});
    directed("subnorm", 16'h0155, {16'h0000, 2'b00});
    directed("max_e14", 16'h77FF, {16'h7FF0, 2'b00});
    directed("sat_pos", 16'h7800, {16'h7FFF, 2'b10});
    directed("sat_neg", 16'hF800, {16'h8000, 2'b10});
    directed("exp31",   16'h7C00, {16'h7FFF, 2'b10});
    directed("one_p5",  16'h3E00, r_3e00);
    directed("neg_1p5", 16'hBE00, r_be00);
    directed("zp75",    16'h3A00, r_3a00);
    directed("half",    16'h3800, {16'h0000, 2'b01});
    directed("three",   16'h4200, {16'h0003, 2'b00});

    // Backpressure: three words offered with the consumer stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk); chk("bp_acc0", in_ready, 1);
    @(posedge clk); #1 in_data = 16'h4200;
    @(negedge clk); chk("bp_acc1", in_ready, 1);
    @(posedge clk); #1 in_data = 16'hBC00;
    @(negedge clk); chk("bp_full", in_ready, 0);
    chk("bp_head", {out_valid, out_data}, {1'b1, 16'h0001});
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk); chk("bp_full_hold", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    n0 = n_out;
    @(negedge clk); chk("bp_acc2", in_ready, 1); chk("bp_out0", out_valid, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("bp_out1", out_valid, 1);
    @(negedge clk); chk("bp_out2", out_valid, 1);
    @(posedge clk); #1;
    chk("bp_count", n_out - n0, 3);

    // Random soak with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          offer(rand_word());
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          out_ready = ($urandom_range(0, 9) < 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    cnt = 0;
    while (n_out != n_in && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("soak_count", n_out, n_in);
    chk("soak_empty", expq.size(), 0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    offer(16'h3C00);
    offer(16'hBC00);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {out_valid, out_data, out_sat, out_inexact}, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    directed("post_rst", 16'h4200, {16'h0003, 2'b00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
